// File: rtl/divider_if.sv
// Request/response bundle between the multdiv control logic and the divider.
// Valid/ready semantics: ctrl_DIV is a one-edge start request that is always accepted
// (it also aborts any operation in flight); data_resultRDY is a one-cycle completion
// strobe with no back-pressure, and data_result/data_exception are valid while it is high.
interface divider_if;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/divider.sv
// Sequential 32-bit signed divider: radix-2 restoring division on magnitudes,
// one quotient bit per cycle, quotient truncated toward zero.
module divider (
    input  logic       clock,
    input  logic       reset,
    divider_if.slave   bus,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_cnt;
    logic [31:0] r_div;
    logic [63:0] r_rq;
    logic        r_sign;
    logic        r_exc;
    logic [31:0] r_result;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic        w_ovf;
    logic        w_special;
    logic        w_last;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [63:0] w_rq_nxt;
    logic [31:0] w_quot_signed;

    // Magnitudes are taken as unsigned, so the most negative value maps to 0x80000000.
    assign w_a_mag    = bus.data_operandA[31] ? (~bus.data_operandA + 32'd1) : bus.data_operandA;
    assign w_b_mag    = bus.data_operandB[31] ? (~bus.data_operandB + 32'd1) : bus.data_operandB;
    assign w_div_zero = (bus.data_operandB == 32'd0);
    assign w_ovf      = (bus.data_operandA == 32'h8000_0000) && (bus.data_operandB == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero | w_ovf;
    assign w_last     = (r_cnt == 6'd31);

    // Shifted remainder kept 33 bits wide so the trial subtract never loses a carry.
    assign w_rem_sh      = r_rq[63:31];
    assign w_ge          = (w_rem_sh >= {1'b0, r_div});
    assign w_diff        = w_rem_sh[31:0] - r_div;
    assign w_rq_nxt      = w_ge ? {w_diff, r_rq[30:0], 1'b1} : {r_rq[62:0], 1'b0};
    assign w_quot_signed = r_sign ? (~w_rq_nxt[31:0] + 32'd1) : w_rq_nxt[31:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_IDLE;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.ctrl_DIV) begin
            w_state_nxt = w_special ? S_DONE : S_RUN;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt    <= 6'd0;
            r_div    <= 32'd0;
            r_rq     <= 64'd0;
            r_sign   <= 1'b0;
            r_exc    <= 1'b0;
            r_result <= 32'd0;
        end else if (bus.ctrl_DIV) begin
            r_rq   <= {32'd0, w_a_mag};
            r_div  <= w_b_mag;
            r_sign <= bus.data_operandA[31] ^ bus.data_operandB[31];
            r_cnt  <= 6'd0;
            if (w_div_zero) begin
                r_result <= 32'd0;
                r_exc    <= 1'b1;
            end else if (w_ovf) begin
                r_result <= 32'h8000_0000;
                r_exc    <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_rq  <= w_rq_nxt;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
                r_result <= w_quot_signed;
                r_exc    <= 1'b0;
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = (r_state == S_DONE);
    assign o_dbg_state        = r_state;

endmodule
